// File: rtl/receiver_pkg.sv
// receiver_pkg: shared constants for the receiver back end.
// Convolutional code generators, scrambler taps, FSM state codes and defaults.
package receiver_pkg;
  localparam int DEF_SYNC_LEN = 16;
  localparam int DEF_SFD_LEN = 48;
  localparam int DEF_N_PAIRS = 216;
  localparam logic [6:0] DEF_SEED = 7'h7F;
  localparam logic [6:0] G0 = 7'o133;
  localparam logic [6:0] G1 = 7'o171;
  localparam logic [6:0] SCR_TAPS = 7'b1001000;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_SFD = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;
  // Generator parity over {current bit, history newest..oldest}; MSB of g is the current-bit tap.
  function automatic logic conv_bit(input logic [6:0] g, input logic b, input logic [5:0] s);
    return ^(g & {b, s[0], s[1], s[2], s[3], s[4], s[5]});
  endfunction
endpackage

// File: rtl/receiver_scrambler7.sv
// scrambler7: 7-bit additive LFSR (x^7+x^4+1) with synchronous load and step.
module scrambler7
  import receiver_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_step,
  input  logic [6:0] i_seed,
  output logic       o_k
);
  logic [6:0] r_state;
  logic       w_k;
  assign w_k = ^(r_state & SCR_TAPS);
  assign o_k = w_k;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= DEF_SEED;
    else if (i_load) r_state <= i_seed;
    else if (i_step) r_state <= {r_state[5:0], w_k};
endmodule

// File: rtl/receiver.sv
// receiver: preamble lock, rate-1/2 K=7 hard-decision decode with parity check,
// and descrambling into a registered serial bit stream plus sticky error flag.
module receiver
  import receiver_pkg::*;
#(
  parameter int         SYNC_LEN = DEF_SYNC_LEN,
  parameter int         SFD_LEN  = DEF_SFD_LEN,
  parameter int         N_PAIRS  = DEF_N_PAIRS,
  parameter logic [6:0] SEED     = DEF_SEED
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_data,
  output logic o_data,
  output logic o_err
);
  localparam int CW = $clog2(SFD_LEN + 1);
  localparam int PW = $clog2(N_PAIRS + 1);
  logic          r_sym_en, r_prev, r_ph, r_c0, r_tail, r_data, r_err;
  logic [1:0]    r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n, w_cnt_inc;
  logic [PW-1:0] r_pairs;
  logic [5:0]    r_hist;
  logic          w_samp, w_pair, w_last, w_go_data, w_b, w_c1, w_k;
  assign w_samp    = r_sym_en && r_state != ST_DATA;
  assign w_pair    = r_state == ST_DATA && r_ph;
  assign w_last    = r_pairs == PW'(N_PAIRS - 1);
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_go_data = r_state == ST_SFD && w_state_n == ST_DATA;
  assign w_b       = r_c0 ^ conv_bit(G0, 1'b0, r_hist);
  assign w_c1      = conv_bit(G1, w_b, r_hist);
  assign o_data    = r_data;
  assign o_err     = r_err;
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    if (w_samp)
      case (r_state)
        ST_IDLE: begin
          w_cnt_n   = (i_data != r_prev) ? w_cnt_inc : CW'(1);
          w_state_n = (w_cnt_n == CW'(SYNC_LEN)) ? ST_SYNC : ST_IDLE;
        end
        ST_SYNC: begin
          w_cnt_n   = (!i_data && !r_prev) ? CW'(2) : r_cnt;
          w_state_n = (!i_data && !r_prev) ? ST_SFD : ST_SYNC;
        end
        ST_SFD: begin
          w_cnt_n   = i_data ? CW'(1) : (w_cnt_inc == CW'(SFD_LEN)) ? '0 : w_cnt_inc;
          w_state_n = i_data ? ST_IDLE : (w_cnt_inc == CW'(SFD_LEN)) ? ST_DATA : ST_SFD;
        end
        default: ;
      endcase
    else if (w_pair && w_last)
      w_state_n = ST_IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_sym_en <= 1'b0;
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_prev   <= 1'b0;
    end else begin
      r_sym_en <= !r_sym_en;
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      if (w_samp) r_prev <= i_data;
    end
  // Output is held for one extra clock after the last pair so every bit spans two clocks.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_ph    <= 1'b0;
      r_c0    <= 1'b0;
      r_tail  <= 1'b0;
      r_data  <= 1'b0;
      r_err   <= 1'b0;
      r_pairs <= '0;
      r_hist  <= '0;
    end else if (w_go_data) begin
      r_ph    <= 1'b0;
      r_tail  <= 1'b0;
      r_data  <= 1'b0;
      r_err   <= 1'b0;
      r_pairs <= '0;
      r_hist  <= '0;
    end else if (r_state == ST_DATA) begin
      r_ph <= !r_ph;
      if (!r_ph) r_c0 <= i_data;
      else begin
        r_hist  <= {r_hist[4:0], w_b};
        r_data  <= w_b ^ w_k;
        r_pairs <= r_pairs + PW'(1);
        r_tail  <= w_last;
        if (w_c1 != i_data) r_err <= 1'b1;
      end
    end else begin
      r_tail <= 1'b0;
      if (!r_tail) r_data <= 1'b0;
    end
  scrambler7 u_scr (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_load (w_go_data),
    .i_step (w_pair),
    .i_seed (SEED),
    .o_k    (w_k)
  );
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: scoreboard bench; stimulus queues expected Output/Error per cycle,
// a negedge monitor pops and compares.
module tb_receiver;
  import receiver_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, din = 1'b0;
  logic dout, derr;
  receiver dut (.i_clk(clk), .i_rst_n(rst_n), .i_data(din), .o_data(dout), .o_err(derr));
  always #5 clk = ~clk;
  typedef struct {int cyc; logic out; logic err; int tag;} exp_t;
  exp_t q[$];
  int cyc = 0, total = 0, bad = 0, tag = 0;
  logic cur_err = 1'b0;
  logic kk[DEF_N_PAIRS];
  logic fd[DEF_N_PAIRS];
  logic fx[DEF_N_PAIRS];
  logic [1:7] xr;
  logic [0:15] hand;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.cyc < cyc || dout !== e.out || derr !== e.err) begin
        bad++;
        $display("FAIL t%0d cyc=%0d(want %0d) out=%b err=%b want out=%b err=%b",
                 e.tag, cyc, e.cyc, dout, derr, e.out, e.err);
      end
    end
  end
  task automatic drive(input logic b, input logic chk, input logic eo, input logic ee);
    exp_t e;
    din = b;
    if (chk) begin
      e.cyc = cyc + 1; e.out = eo; e.err = ee; e.tag = tag;
      q.push_back(e);
    end
    @(negedge clk);
  endtask
  task automatic sym(input logic b, input logic last);
    drive(b, 1'b0, 1'b0, 1'b0);
    drive(b, 1'b1, 1'b0, last ? 1'b0 : cur_err);
  endtask
  task automatic preamble(input int bad_pos);
    for (int i = 0; i < DEF_SYNC_LEN; i++) sym((i % 2) == 1, 1'b0);
    for (int j = 1; j <= DEF_SFD_LEN; j++) sym(j == bad_pos, bad_pos == 0 && j == DEF_SFD_LEN);
    if (bad_pos == 0) cur_err = 1'b0;
  endtask
  task automatic gap(input int n, input logic b);
    for (int i = 0; i < n; i++) drive(b, i >= 1, 1'b0, cur_err);
  endtask
  // Reference encoder: w[j] is the data bit delayed j pairs; taps read off 133 and 171 octal.
  task automatic run_frame(input int flip, input int npairs);
    logic [0:6] w;
    logic c0, c1, prev_out;
    w = '0;
    prev_out = 1'b0;
    preamble(0);
    for (int i = 0; i < npairs; i++) begin
      w = {fd[i], w[0:5]};
      c0 = w[0] ^ w[2] ^ w[3] ^ w[5] ^ w[6];
      c1 = w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[6];
      drive(c0, 1'b1, prev_out, cur_err);
      if (i == flip) begin
        c1 = ~c1;
        cur_err = 1'b1;
      end
      drive(c1, 1'b1, fx[i], cur_err);
      prev_out = fx[i];
    end
  endtask
  task automatic check_now(input int t);
    total++;
    if (dout !== 1'b0 || derr !== 1'b0) begin
      bad++;
      $display("FAIL t%0d reset out=%b err=%b want out=0 err=0", t, dout, derr);
    end
  endtask
  initial begin
    xr = 7'h7F;
    for (int i = 0; i < DEF_N_PAIRS; i++) begin
      kk[i] = xr[7] ^ xr[4];
      xr = {kk[i], xr[1:6]};
    end
    hand = 16'b0000_1110_1111_0010;
    repeat (2) @(negedge clk);
    check_now(0);
    rst_n = 1'b1;
    tag = 0; gap(2, 1'b0);
    tag = 1;
    for (int i = 0; i < DEF_N_PAIRS; i++) begin
      fd[i] = 1'b0;
      fx[i] = (i < 16) ? hand[i] : kk[i];
    end
    run_frame(-1, DEF_N_PAIRS); gap(4, 1'b0);
    tag = 2;
    for (int i = 0; i < DEF_N_PAIRS; i++) begin
      fx[i] = (i == 0 || i == 3);
      fd[i] = fx[i] ^ kk[i];
    end
    run_frame(-1, DEF_N_PAIRS); gap(4, 1'b0);
    tag = 3;
    for (int i = 0; i < DEF_N_PAIRS; i++) begin
      fx[i] = ($urandom_range(1) != 0);
      fd[i] = fx[i] ^ kk[i];
    end
    run_frame(2, DEF_N_PAIRS); gap(4, 1'b0);
    tag = 4;
    for (int i = 0; i < DEF_N_PAIRS; i++) begin
      fx[i] = ($urandom_range(1) != 0);
      fd[i] = fx[i] ^ kk[i];
    end
    run_frame(-1, DEF_N_PAIRS); gap(4, 1'b0);
    tag = 5;
    preamble(30); gap(40, 1'b1);
    tag = 6;
    for (int i = 0; i < DEF_N_PAIRS; i++) begin
      fx[i] = (i == 9) ? 1'b1 : ($urandom_range(1) != 0);
      fd[i] = fx[i] ^ kk[i];
    end
    run_frame(4, 10);
    #2 rst_n = 1'b0;
    #1 check_now(6);
    cur_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tag = 7; gap(2, 1'b0);
    for (int i = 0; i < DEF_N_PAIRS; i++) begin
      fx[i] = ($urandom_range(1) != 0);
      fd[i] = fx[i] ^ kk[i];
    end
    run_frame(-1, DEF_N_PAIRS); gap(4, 1'b0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/receiver.md
# receiver

Bit-serial baseband receiver back end for the 802.11a-style link. It locks onto a preamble, then recovers payload bits from the rate-1/2, K=7 convolutional code, checks parity consistency and descrambles. It sits after the demodulator/slicer and delivers a serial decoded bit stream with a sticky error flag to the MAC-side logic.

## Interface
- SYNC_LEN, 16: minimum alternating 1/0 symbols needed to declare preamble.
- SFD_LEN, 48: consecutive zero symbols that end the preamble.
- N_PAIRS, 216: coded bit pairs per frame.
- SEED, 7'h7F: scrambler initial state.
- Clock  in  1  single clock at coded-bit rate; rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Input  in  1  received hard bit; preamble symbols last 2 clocks each, coded bits 1 clock each.
- Output  out  1  descrambled payload bit, registered.
- Error  out  1  sticky code-violation flag, registered.

## Operation
- Internal half-rate enable `sym_en` toggles every clock after reset; preamble logic samples Input only when `sym_en`=1.
- States: IDLE, SYNC, SFD, DATA.
- IDLE: on sym_en, a bit differing from the previous sampled bit increments the alternation count; an equal bit resets it to 1. Count = SYNC_LEN -> SYNC.
- SYNC: alternation continues; first sampled 0 following a sampled 0 moves to SFD with zero count 2; any other break of alternation before that keeps SYNC.
- SFD: sampled 0 increments zero count; sampled 1 -> IDLE. Zero count = SFD_LEN -> DATA on the next clock; encoder state cleared to 0, scrambler loaded with SEED, pair counter cleared, Error cleared.
- DATA: first clock captures c0 (g0=133 octal), second captures c1 (g1=171 octal).
- Decode per pair: 6-bit history s (previous data bits, s[0] newest). b = c0 XOR s[1] XOR s[2] XOR s[4] XOR s[5]. Expected c1 = b XOR s[0] XOR s[1] XOR s[2] XOR s[5]. Mismatch sets Error (sticky until next frame start or reset). s shifts in b.
- Descramble: x^7+x^4+1 additive; k = x7 XOR x4, state shifts k in; Output = b XOR k, registered on the c1 clock and held 2 clocks.
- After N_PAIRS pairs -> IDLE; Output returns to 0, Error retained. A trailing unpaired bit is ignored.
- Reset (any time, including mid-frame): state IDLE, counters 0, Output=0, Error=0, sym_en=0.

## Timing
- Preamble detection is purely sequential; no output activity.
- DATA entry: 1 clock after last SFD zero sampled.
- Latency: Output updates on the rising edge that samples c1, valid from that edge through 2 clocks.
- Error asserts on the same edge as the Output update of the offending pair.
- Input timing: bits stable around the rising edge; no metastability handling required.

## Structure
- Shared package: state enum, G0/G1 tap constants, scrambler polynomial taps, default SEED.
- Natural sub-module: `scrambler7` (7-bit LFSR with load and step); sync FSM and decoder in the top level.

## Test plan
- Reset mid-DATA -> Output=0, Error=0 immediately (asynchronous); the next frame decodes normally.
- 16 alternating symbols (2 clocks each), 48 zeros, then all-zero coded pairs -> Output sequence 0,0,0,0,1,1,1,0,1,1,1,1,0,0,1,0 (one bit per pair), Error=0.
- Encode payload 1,0,0,1 (K=7, g0/g1, zero start) after the same preamble, with the scrambler XOR pre-applied -> Output 1,0,0,1, Error=0.
- Flip c1 of pair 3 -> Error rises at that pair's c1 edge, stays 1 through frame end and in IDLE.
- Preamble with a 1 at zero position 30 of SFD -> returns to IDLE, no DATA, Output stays 0.
- After a full frame of N_PAIRS pairs, a second valid preamble -> Error cleared at DATA entry, second frame decodes correctly.
